// File: rtl/up_dn_sweep_ctrl_pkg.sv
// Shared types and default widths for the up/down sweep controller.
// Imported by the controller and its interface.
package up_dn_sweep_ctrl_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_RPT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_S = 3'd1,
    UP_S   = 3'd2,
    DOWN_S = 3'd3,
    DONE_S = 3'd4
  } state_t;

endpackage

// File: rtl/up_dn_sweep_ctrl_if.sv
// Control/feedback bundle between a sweep requester, the sweep controller
// and the external up/down counter.
interface up_dn_sweep_ctrl_if
  import up_dn_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RPT_W = DEF_RPT_W
);

  logic             start;
  logic             stop;
  logic [WIDTH-1:0] LO_BOUND;
  logic [WIDTH-1:0] HI_BOUND;
  logic [RPT_W-1:0] REPEAT;
  logic [WIDTH-1:0] Counter;
  logic [WIDTH-1:0] IN;
  logic             LOAD;
  logic             Up;
  logic             Down;
  logic             busy;
  logic             done;
  logic             err;

  // Requester side: issues sweep requests, supplies counter feedback.
  modport master (
    output start, stop, LO_BOUND, HI_BOUND, REPEAT, Counter,
    input  IN, LOAD, Up, Down, busy, done, err
  );

  // Controller side.
  modport slave (
    input  start, stop, LO_BOUND, HI_BOUND, REPEAT, Counter,
    output IN, LOAD, Up, Down, busy, done, err
  );

endinterface

// File: rtl/up_dn_sweep_ctrl.sv
// Triangle-sweep controller: drives an external up/down counter from lo to hi
// and back, REPEAT times, watching its value to detect the turning points.
module up_dn_sweep_ctrl
  import up_dn_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RPT_W = DEF_RPT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  up_dn_sweep_ctrl_if.slave bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo_q, lo_nxt;
  logic [WIDTH-1:0] hi_q, hi_nxt;
  logic [RPT_W-1:0] rpt_q, rpt_nxt;
  logic [RPT_W-1:0] tri_q, tri_nxt;
  logic [RPT_W-1:0] tri_inc, target;
  logic             err_q, err_nxt;
  logic             at_hi, at_lo, out_of_range;

  assign at_hi        = (bus.Counter == hi_q);
  assign at_lo        = (bus.Counter == lo_q);
  assign out_of_range = (bus.Counter < lo_q) || (bus.Counter > hi_q);

  // Triangle count saturates instead of wrapping; REPEAT of 0 means one pass.
  assign tri_inc = (tri_q == '1) ? tri_q : tri_q + 1'b1;
  assign target  = (rpt_q == '0) ? RPT_W'(1) : rpt_q;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    lo_nxt    = lo_q;
    hi_nxt    = hi_q;
    rpt_nxt   = rpt_q;
    tri_nxt   = tri_q;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.LO_BOUND < bus.HI_BOUND) begin
            lo_nxt    = bus.LO_BOUND;
            hi_nxt    = bus.HI_BOUND;
            rpt_nxt   = bus.REPEAT;
            tri_nxt   = '0;
            state_nxt = LOAD_S;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      LOAD_S: state_nxt = bus.stop ? IDLE : UP_S;
      UP_S: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (out_of_range) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (at_hi) begin
          state_nxt = DOWN_S;
        end
      end
      DOWN_S: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (out_of_range) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (at_lo) begin
          tri_nxt   = tri_inc;
          state_nxt = (tri_inc >= target) ? DONE_S : UP_S;
        end
      end
      DONE_S:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lo_q  <= '0;
      hi_q  <= '0;
      rpt_q <= '0;
      tri_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      lo_q  <= lo_nxt;
      hi_q  <= hi_nxt;
      rpt_q <= rpt_nxt;
      tri_q <= tri_nxt;
      err_q <= err_nxt;
    end
  end

  // Counter controls decode from state and feedback only; err is registered so
  // it stays low while reset holds the FSM in IDLE.
  assign bus.IN   = lo_q;
  assign bus.LOAD = (state == LOAD_S);
  assign bus.Up   = (state == UP_S) && !at_hi;
  assign bus.Down = (state == DOWN_S) && !at_lo;
  assign bus.busy = (state == LOAD_S) || (state == UP_S) || (state == DOWN_S);
  assign bus.done = (state == DONE_S);
  assign bus.err  = err_q;

endmodule

// File: tb/tb_up_dn_sweep_ctrl.sv
// Directed bench for up_dn_sweep_ctrl with a behavioural up/down counter
// closing the Counter feedback loop.
module tb_up_dn_sweep_ctrl;

  logic clk;
  logic rst_n;

  up_dn_sweep_ctrl_if #(.WIDTH(5), .RPT_W(4)) bus ();

  up_dn_sweep_ctrl #(.WIDTH(5), .RPT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural counter sitting beside the controller, with a fault override.
  logic       force_en  = 1'b0;
  logic [4:0] force_val = '0;

  always @(posedge clk) begin
    if (!rst_n)         bus.Counter <= '0;
    else if (force_en)  bus.Counter <= force_val;
    else if (bus.LOAD)  bus.Counter <= bus.IN;
    else if (bus.Up)    bus.Counter <= bus.Counter + 5'd1;
    else if (bus.Down)  bus.Counter <= bus.Counter - 5'd1;
  end

  // Running event counters; tests take deltas around each scenario.
  int n_done = 0, n_load = 0, n_err = 0, n_busy = 0;
  int n_excl = 0, n_ovf = 0, n_unf = 0;

  always @(negedge clk) begin
    if (bus.done) n_done++;
    if (bus.LOAD) n_load++;
    if (bus.err)  n_err++;
    if (bus.busy) n_busy++;
    if (int'(bus.Up) + int'(bus.Down) + int'(bus.LOAD) > 1) n_excl++;
    if (bus.Up && bus.Counter == 5'd31) n_ovf++;
    if (bus.Down && bus.Counter == 5'd0) n_unf++;
  end

  task automatic start_sweep(input logic [4:0] lo, input logic [4:0] hi,
                             input logic [3:0] rpt);
    bus.LO_BOUND = lo;
    bus.HI_BOUND = hi;
    bus.REPEAT   = rpt;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Waits at negedges for the done pulse; seen=0 if the budget expires.
  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [10:0] outs;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.LO_BOUND = '0; bus.HI_BOUND = '0; bus.REPEAT = '0;
    repeat (3) @(negedge clk);
    outs = {bus.IN, bus.LOAD, bus.Up, bus.Down, bus.busy, bus.done, bus.err};
    total++;
    if (outs !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b", outs, 11'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int exp_seq [0:8] = '{10, 11, 12, 13, 13, 12, 11, 10, 10};
    int d0 = n_done;
    start_sweep(5'd10, 5'd13, 4'd1);
    total++;
    if ({bus.LOAD, bus.IN, bus.busy} !== {1'b1, 5'd10, 1'b1}) begin
      bad++;
      $display("FAIL basic_load got LOAD=%b IN=%0d busy=%b exp LOAD=1 IN=10 busy=1",
               bus.LOAD, bus.IN, bus.busy);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      total++;
      if (int'(bus.Counter) !== exp_seq[i]) begin
        bad++;
        $display("FAIL basic_counter[%0d] got=%0d exp=%0d", i, bus.Counter, exp_seq[i]);
      end
    end
    total++;
    if ({bus.done, bus.busy, bus.Up, bus.Down} !== 4'b1000) begin
      bad++;
      $display("FAIL basic_done got done=%b busy=%b Up=%b Down=%b exp 1 0 0 0",
               bus.done, bus.busy, bus.Up, bus.Down);
    end
    @(negedge clk);
    total++;
    if ({bus.done, bus.IN, n_done - d0} !== {1'b0, 5'd10, 32'd1}) begin
      bad++;
      $display("FAIL basic_after got done=%b IN=%0d pulses=%0d exp done=0 IN=10 pulses=1",
               bus.done, bus.IN, n_done - d0);
    end
  endtask

  task automatic test_full_range;
    int d0 = n_done, b0 = n_busy, o0 = n_ovf, u0 = n_unf, x0 = n_excl;
    bit seen;
    start_sweep(5'd0, 5'd31, 4'd2);
    wait_done(400, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL full_timeout got=no_done exp=done within 400 cycles");
    end
    @(negedge clk);
    total++;
    if (n_busy - b0 !== 129) begin
      bad++;
      $display("FAIL full_busy_cycles got=%0d exp=129", n_busy - b0);
    end
    total++;
    if ({n_done - d0, n_ovf - o0, n_unf - u0, n_excl - x0} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL full_events got done=%0d ovf=%0d unf=%0d excl=%0d exp 1 0 0 0",
               n_done - d0, n_ovf - o0, n_unf - u0, n_excl - x0);
    end
  endtask

  task automatic test_bad_config;
    logic [4:0] los [0:1] = '{5'd20, 5'd7};
    logic [4:0] his [0:1] = '{5'd20, 5'd3};
    for (int k = 0; k < 2; k++) begin
      int l0 = n_load, b0 = n_busy, e0 = n_err;
      start_sweep(los[k], his[k], 4'd1);
      total++;
      if ({bus.err, bus.busy} !== 2'b10) begin
        bad++;
        $display("FAIL badcfg%0d_pulse got err=%b busy=%b exp err=1 busy=0", k, bus.err, bus.busy);
      end
      repeat (2) @(negedge clk);
      total++;
      if ({n_load - l0, n_busy - b0, n_err - e0} !== {32'd0, 32'd0, 32'd1}) begin
        bad++;
        $display("FAIL badcfg%0d_events got load=%0d busy=%0d err=%0d exp 0 0 1",
                 k, n_load - l0, n_busy - b0, n_err - e0);
      end
    end
  endtask

  task automatic test_stop;
    int d0 = n_done;
    bit hit = 1'b0;
    start_sweep(5'd10, 5'd13, 4'd1);
    for (int i = 0; i < 20 && !hit; i++) begin
      if (bus.Up && bus.Counter == 5'd12) hit = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL stop_reach got=no_counter12 exp=Up at Counter=12");
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    total++;
    if ({bus.busy, bus.Up, bus.Down, bus.Counter} !== {3'b000, 5'd13}) begin
      bad++;
      $display("FAIL stop_idle got busy=%b Up=%b Down=%b Counter=%0d exp 0 0 0 13",
               bus.busy, bus.Up, bus.Down, bus.Counter);
    end
    repeat (4) @(negedge clk);
    total++;
    if ({bus.Counter, n_done - d0} !== {5'd13, 32'd0}) begin
      bad++;
      $display("FAIL stop_hold got Counter=%0d done=%0d exp Counter=13 done=0",
               bus.Counter, n_done - d0);
    end
  endtask

  task automatic test_track_err;
    int d0 = n_done;
    bit hit = 1'b0;
    start_sweep(5'd10, 5'd13, 4'd1);
    for (int i = 0; i < 20 && !hit; i++) begin
      if (bus.Down) hit = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL track_reach got=no_down exp=Down asserted");
    end
    force_en  = 1'b1;
    force_val = 5'd25;
    @(negedge clk);
    force_en  = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.err, bus.busy} !== 2'b10) begin
      bad++;
      $display("FAIL track_err got err=%b busy=%b exp err=1 busy=0", bus.err, bus.busy);
    end
    @(negedge clk);
    total++;
    if ({bus.err, bus.busy, n_done - d0} !== {2'b00, 32'd0}) begin
      bad++;
      $display("FAIL track_after got err=%b busy=%b done=%0d exp 0 0 0",
               bus.err, bus.busy, n_done - d0);
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] outs;
    bit hit = 1'b0;
    bit seen;
    int b0;
    start_sweep(5'd10, 5'd13, 4'd1);
    for (int i = 0; i < 20 && !hit; i++) begin
      if (bus.Down && bus.Counter == 5'd12) hit = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL rstmid_reach got=no_down12 exp=Down at Counter=12");
    end
    rst_n = 1'b0;
    #1;
    outs = {bus.IN, bus.LOAD, bus.Up, bus.Down, bus.busy, bus.done, bus.err};
    total++;
    if (outs !== 11'd0) begin
      bad++;
      $display("FAIL rstmid_outputs got=%b exp=%b", outs, 11'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b0 = n_busy;
    start_sweep(5'd3, 5'd5, 4'd3);
    total++;
    if ({bus.LOAD, bus.IN} !== {1'b1, 5'd3}) begin
      bad++;
      $display("FAIL rstmid_load got LOAD=%b IN=%0d exp LOAD=1 IN=3", bus.LOAD, bus.IN);
    end
    wait_done(100, seen);
    @(negedge clk);
    total++;
    if ({seen, n_busy - b0} !== {1'b1, 32'd19}) begin
      bad++;
      $display("FAIL rstmid_sweep got done_seen=%b busy=%0d exp 1 19", seen, n_busy - b0);
    end
  endtask

  // REPEAT 0 acts as 1, REPEAT at the count maximum, and a start pulse issued
  // mid-sweep that must not disturb the latched bounds or the cycle count.
  task automatic test_repeat;
    logic [4:0] los  [0:2] = '{5'd1, 5'd0, 5'd3};
    logic [4:0] his  [0:2] = '{5'd2, 5'd1, 5'd5};
    logic [3:0] rpts [0:2] = '{4'd0, 4'd15, 4'd3};
    int         exp_busy [0:2] = '{5, 61, 19};
    for (int k = 0; k < 3; k++) begin
      int b0 = n_busy, d0 = n_done;
      bit seen;
      start_sweep(los[k], his[k], rpts[k]);
      @(negedge clk);
      start_sweep(5'd8, 5'd30, 4'd9);
      total++;
      if (bus.IN !== los[k]) begin
        bad++;
        $display("FAIL repeat%0d_busy_start got IN=%0d exp=%0d", k, bus.IN, los[k]);
      end
      wait_done(200, seen);
      @(negedge clk);
      total++;
      if ({seen, n_busy - b0, n_done - d0} !== {1'b1, exp_busy[k], 32'd1}) begin
        bad++;
        $display("FAIL repeat%0d_cycles got seen=%b busy=%0d done=%0d exp 1 %0d 1",
                 k, seen, n_busy - b0, n_done - d0, exp_busy[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full_range;
    test_bad_config;
    test_stop;
    test_track_err;
    test_reset_mid;
    test_repeat;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
